// File: rtl/mmram_ce_sched_pkg.sv
// mmram_ce_sched_pkg: FSM state encoding and Exb polarity shared by the MMRAM CE scheduler.
package mmram_ce_sched_pkg;
    typedef enum logic [2:0] {
        S_IDLE, S_ARB, S_LOOKUP, S_DECIDE, S_SETUP, S_SEND, S_RELEASE, S_DONE
    } state_t;
    localparam logic EXB_PASS = 1'b1;
    localparam logic EXB_DEL  = 1'b0;
endpackage

// File: rtl/mmram_ce_sched_rr_arbiter.sv
// mmram_ce_sched_rr_arbiter: picks the first active requester at or after the round-robin pointer.
module mmram_ce_sched_rr_arbiter #(
    parameter int N_REQ = 4
)(
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_ptr,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_gnt_idx,
    output logic                     o_any
);
    localparam int PW = $clog2(N_REQ);
    logic [PW:0] w_idx;
    logic        w_found;
    // Wrap by compare so non-power-of-two requester counts rotate correctly.
    always_comb begin
        o_gnt     = '0;
        o_gnt_idx = '0;
        w_found   = 1'b0;
        w_idx     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = {1'b0, i_ptr} + (PW+1)'(k);
            if (w_idx >= (PW+1)'(N_REQ)) w_idx = w_idx - (PW+1)'(N_REQ);
            if (!w_found && i_req[w_idx[PW-1:0]]) begin
                o_gnt[w_idx[PW-1:0]] = 1'b1;
                o_gnt_idx            = w_idx[PW-1:0];
                w_found              = 1'b1;
            end
        end
    end
    assign o_any = |i_req;
endmodule

// File: rtl/mmram_ce_sched.sv
// mmram_ce_sched: arbitrates token requesters, does the matching-memory lookup/update and
// runs one 4-phase Send/Ack handshake with Exb into the self-timed CE stage.
module mmram_ce_sched
    import mmram_ce_sched_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int TAG_W = 8,
    parameter int TMO_W = 8
)(
    input  logic                   CLK,
    input  logic                   MR_n,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*TAG_W-1:0] req_tag,
    output logic [N_REQ-1:0]       grant,
    output logic [N_REQ-1:0]       done,
    output logic [TAG_W-1:0]       mem_addr,
    output logic                   mem_rd,
    input  logic                   mem_hit,
    output logic                   mem_wr,
    output logic                   mem_wr_v,
    output logic                   CE_Send,
    input  logic                   CE_Ack,
    output logic                   CE_Exb,
    output logic                   err
);
    localparam int PW = $clog2(N_REQ);
    state_t             r_state;
    logic [N_REQ-1:0]   r_grant, r_done;
    logic [TAG_W-1:0]   r_tag;
    logic [PW-1:0]      r_ptr, r_gidx;
    logic [TMO_W-1:0]   r_cnt;
    logic               r_mem_rd, r_mem_wr, r_wr_v, r_send, r_exb, r_err, r_ack_m, r_ack_s;
    logic [N_REQ-1:0]   w_gnt;
    logic [PW-1:0]      w_gidx, w_ptr_nxt;
    logic               w_any;

    mmram_ce_sched_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req(req), .i_ptr(r_ptr), .o_gnt(w_gnt), .o_gnt_idx(w_gidx), .o_any(w_any)
    );

    assign w_ptr_nxt = (r_gidx == PW'(N_REQ-1)) ? '0 : r_gidx + 1'b1;

    always_ff @(posedge CLK or negedge MR_n) begin
        if (!MR_n) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_done  <= '0;
            r_tag   <= '0;
            r_ptr   <= '0;
            r_gidx  <= '0;
            r_cnt   <= '0;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_wr_v  <= 1'b0;
            r_send  <= 1'b0;
            r_exb   <= 1'b0;
            r_err   <= 1'b0;
            r_ack_m <= 1'b0;
            r_ack_s <= 1'b0;
        end else begin
            r_ack_m  <= CE_Ack;
            r_ack_s  <= r_ack_m;
            r_mem_rd <= 1'b0;
            r_mem_wr <= 1'b0;
            r_done   <= '0;
            case (r_state)
                S_IDLE: if (|req) r_state <= S_ARB;
                S_ARB: begin
                    if (w_any) begin
                        r_grant  <= w_gnt;
                        r_gidx   <= w_gidx;
                        r_tag    <= req_tag[w_gidx*TAG_W +: TAG_W];
                        r_mem_rd <= 1'b1;
                        r_state  <= S_LOOKUP;
                    end else begin
                        r_state  <= S_IDLE;
                    end
                end
                S_LOOKUP: r_state <= S_DECIDE;
                S_DECIDE: begin
                    r_exb    <= mem_hit ? EXB_PASS : EXB_DEL;
                    r_mem_wr <= 1'b1;
                    r_wr_v   <= ~mem_hit;
                    r_state  <= S_SETUP;
                end
                // Exb is captured by the stage on Send, so it gets a full cycle to settle first.
                S_SETUP: begin
                    if (!r_ack_s) begin
                        r_send  <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND, S_RELEASE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_state == S_SEND && r_ack_s) begin
                        r_send  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_RELEASE;
                    end else if (r_state == S_RELEASE && !r_ack_s) begin
                        r_done  <= r_grant;
                        r_grant <= '0;
                        r_state <= S_DONE;
                    end else if (&r_cnt) begin
                        r_err   <= 1'b1;
                        r_send  <= 1'b0;
                        r_grant <= '0;
                        r_ptr   <= w_ptr_nxt;
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_ptr   <= w_ptr_nxt;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant    = r_grant;
    assign done     = r_done;
    assign mem_addr = r_tag;
    assign mem_rd   = r_mem_rd;
    assign mem_wr   = r_mem_wr;
    assign mem_wr_v = r_wr_v;
    assign CE_Send  = r_send;
    assign CE_Exb   = r_exb;
    assign err      = r_err;
endmodule

// File: tb/tb_mmram_ce_sched.sv
// tb_mmram_ce_sched: randomized request batches against a round-robin/matching-memory
// reference model, with a queue-based monitor checking each service as the DUT reports it.
module tb_mmram_ce_sched;
    localparam int N = 4, TW = 8;

    logic              CLK = 1'b0, MR_n = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N*TW-1:0]   req_tag = '0;
    logic [N-1:0]      grant, done;
    logic [TW-1:0]     mem_addr;
    logic              mem_rd, mem_hit = 1'b0, mem_wr, mem_wr_v, CE_Send, CE_Ack = 1'b0, CE_Exb, err;

    always #5 CLK = ~CLK;

    mmram_ce_sched #(.N_REQ(N), .TAG_W(TW), .TMO_W(8)) dut (
        .CLK(CLK), .MR_n(MR_n), .req(req), .req_tag(req_tag), .grant(grant), .done(done),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_hit(mem_hit), .mem_wr(mem_wr),
        .mem_wr_v(mem_wr_v), .CE_Send(CE_Send), .CE_Ack(CE_Ack), .CE_Exb(CE_Exb), .err(err)
    );

    typedef struct {
        int           idx;
        logic [TW-1:0] tag;
        logic         hit;
        logic         tmo;
    } exp_t;

    exp_t q[$];
    bit   ref_mem[256];
    bit   env_mem[256];
    int   rr_ptr = 0;
    int   checks = 0, failures = 0;
    bit   ack_en = 1'b1;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Reference: serve the batch in cyclic order from the pointer; a tag toggles between stored/empty.
    function automatic void predict(logic [N-1:0] m, logic tmo);
        exp_t e;
        int   last = rr_ptr - 1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (rr_ptr + k) % N;
            if (m[i]) begin
                e.idx = i;
                e.tag = req_tag[i*TW +: TW];
                e.hit = ref_mem[e.tag];
                ref_mem[e.tag] = !e.hit;
                e.tmo = tmo;
                q.push_back(e);
                last = i;
            end
        end
        rr_ptr = (last + 1) % N;
    endfunction

    task automatic set_tags();
        for (int i = 0; i < N; i++) req_tag[i*TW +: TW] = 8'($urandom_range(0, 7));
    endtask

    // Matching memory environment
    always @(negedge CLK) begin
        if (mem_rd) mem_hit = env_mem[mem_addr];
        if (mem_wr) env_mem[mem_addr] = mem_wr_v;
    end

    // CE stage: Ack follows Send after 1..3 cycles per edge
    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (ack_en && CE_Ack !== CE_Send) begin
                int   d;
                logic v;
                d = $urandom_range(1, 3);
                v = CE_Send;
                repeat (d) @(posedge CLK);
                #2;
                if (ack_en) CE_Ack = v;
            end
        end
    end

    initial begin
        exp_t e;
        logic exb_w = 1'b0, exb_ok = 1'b1;
        bit   pe = 1'b0, ps = 1'b0;
        forever begin
            @(negedge CLK);
            if (!MR_n) begin
                pe = 1'b0;
                ps = 1'b0;
            end else begin
                if (mem_rd) begin
                    if (q.size() == 0) chk("rd_unexpected", 32'(mem_rd), 0);
                    else chk("mem_addr", 32'(mem_addr), 32'(q[0].tag));
                end
                if (mem_wr) begin
                    if (q.size() == 0) chk("wr_unexpected", 32'(mem_wr), 0);
                    else chk("mem_wr_v", 32'(mem_wr_v), 32'(!q[0].hit));
                    exb_w  = CE_Exb;
                    exb_ok = 1'b1;
                end else if (CE_Exb !== exb_w) begin
                    exb_ok = 1'b0;
                end
                if (ps && !CE_Send && !(err && !pe)) chk("send_fall_ack", 32'(CE_Ack), 1);
                if (|done) begin
                    if (q.size() == 0) begin
                        chk("done_unexpected", 32'(done), 0);
                    end else begin
                        e = q.pop_front();
                        chk("done_idx", 32'(done), e.tmo ? 32'd0 : 32'(1 << e.idx));
                        chk("exb", {30'd0, exb_ok, CE_Exb}, {30'd0, 1'b1, e.hit});
                        chk("done_ack_low", 32'(CE_Ack), 0);
                    end
                end
                if (err && !pe) begin
                    if (q.size() == 0 || !q[0].tmo) begin
                        chk("err_unexpected", 32'(err), 0);
                    end else begin
                        void'(q.pop_front());
                        chk("tmo_grant_send", {27'd0, grant, CE_Send}, 0);
                    end
                end
                pe = err;
                ps = CE_Send;
            end
        end
    end

    task automatic wait_batch();
        int n = 0;
        while ((q.size() != 0 || req != '0) && n < 3000) begin
            @(negedge CLK);
            req = req & ~done;
            n++;
        end
        chk("batch_complete", 32'(q.size()), 0);
        repeat (3) @(negedge CLK);
    endtask

    task automatic wait_send(string nm);
        int n = 0;
        while (!CE_Send && n < 20) begin
            @(negedge CLK);
            n++;
        end
        chk(nm, 32'(n), 5);
    endtask

    task automatic run_batch(logic [N-1:0] m);
        predict(m, 1'b0);
        req = m;
        wait_send("latency");
        wait_batch();
    endtask

    initial begin
        logic [N-1:0] m;
        int n;
        req = '1;
        set_tags();
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {grant, done, mem_addr, mem_rd, mem_wr, mem_wr_v, CE_Send, CE_Exb, err}, 0);
        predict('1, 1'b0);
        MR_n = 1'b1;
        @(negedge CLK);
        chk("grant_cycle1", 32'(grant), 0);
        @(negedge CLK);
        chk("grant_cycle2", 32'(grant), 32'b0001);
        wait_batch();
        repeat (25) begin
            set_tags();
            m = N'($urandom_range(1, (1 << N) - 1));
            run_batch(m);
        end
        req_tag[0 +: TW] = 8'h2A;
        run_batch(4'b0001);
        req_tag[TW +: TW] = 8'h2A;
        run_batch(4'b0010);
        // Timeout: Ack never answers
        ack_en = 1'b0;
        set_tags();
        m = N'(1 << $urandom_range(0, N - 1));
        predict(m, 1'b1);
        req = m;
        wait_send("tmo_latency");
        n = 0;
        while (!err && n < 400) begin
            @(negedge CLK);
            n++;
        end
        chk("tmo_window", 32'(n >= 255 && n <= 257), 1);
        req = '0;
        ack_en = 1'b1;
        repeat (3) @(negedge CLK);
        set_tags();
        run_batch(N'($urandom_range(1, (1 << N) - 1)));
        chk("err_sticky", 32'(err), 1);
        // Reset in the middle of a handshake
        ack_en = 1'b0;
        set_tags();
        predict(4'b0100, 1'b0);
        req = 4'b0100;
        wait_send("midrst_latency");
        repeat (3) @(negedge CLK);
        #2 MR_n = 1'b0;
        #1 chk("midrst_outputs", {26'd0, CE_Send, grant, err}, 0);
        q.delete();
        req = '0;
        rr_ptr = 0;
        @(negedge CLK);
        MR_n = 1'b1;
        repeat (3) @(negedge CLK);
        chk("idle_after_reset", {25'd0, grant, CE_Send, mem_rd, err}, 0);
        ack_en = 1'b1;
        set_tags();
        run_batch('1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end
endmodule
